// File: rtl/ddr_local_responder.sv
// ddr_local_responder: stand-in for the memory-controller local interface, backed by an internal RAM.
// Serves read/write bursts with programmable read latency, write-data latency and post-command gap.
module ddr_local_responder #(
  parameter int unsigned MEMCONWIDTH    = 128,
  parameter int unsigned MEMCONNUMBYTES = 16,
  parameter int unsigned DDRSIZEWIDTH   = 24,
  parameter int unsigned BURSTWIDTH     = 2,
  parameter int unsigned ADDRW          = 8,
  parameter int unsigned RDATA_LAT      = 2,
  parameter int unsigned WDATA_LAT      = 1,
  parameter int unsigned READY_GAP      = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      mem_read_req,
  input  logic                      mem_write_req,
  input  logic [DDRSIZEWIDTH-1:0]   mem_local_addr,
  input  logic [BURSTWIDTH-1:0]     mem_size,
  input  logic [MEMCONNUMBYTES-1:0] mem_be,
  input  logic [MEMCONWIDTH-1:0]    mem_wdata,
  input  logic                      burst_begin,
  output logic                      mem_ready,
  output logic                      mem_wdata_req,
  output logic [MEMCONWIDTH-1:0]    mem_rdata,
  output logic                      mem_rdata_valid
);

  localparam int unsigned DEPTH = 2 ** ADDRW;

  typedef enum logic [2:0] {StIdle, StRd, StWr, StWdrain, StGap} state_e;

  state_e                      r_state;
  state_e                      w_state_d;
  state_e                      w_post;
  logic [ADDRW-1:0]            r_addr;
  logic [BURSTWIDTH-1:0]       r_size;
  logic [MEMCONNUMBYTES-1:0]   r_be;
  logic [BURSTWIDTH:0]         r_beat;
  logic [15:0]                 r_cnt;
  logic                        r_ready;
  logic                        r_wreq;

  logic [MEMCONWIDTH-1:0]      r_mem [DEPTH];
  logic [RDATA_LAT-1:0]        r_rd_vld;
  logic [MEMCONWIDTH-1:0]      r_rd_dat [RDATA_LAT];
  logic [WDATA_LAT-1:0]        r_wp_vld;
  logic [ADDRW-1:0]            r_wp_addr [WDATA_LAT];

  logic                        w_accept;
  logic                        w_beat_last;
  logic                        w_drain_last;
  logic                        w_gap_last;
  logic                        w_rd_issue;
  logic                        w_wr_issue;
  logic [ADDRW-1:0]            w_beat_addr;
  logic                        w_ready_d;
  logic                        w_wreq_d;
  logic                        w_unused;

  assign w_unused     = ^{burst_begin, mem_local_addr[DDRSIZEWIDTH-1:ADDRW]};
  assign w_accept     = r_ready & (mem_read_req | mem_write_req);
  assign w_beat_last  = ((r_beat + 1'b1) == {1'b0, r_size});
  assign w_drain_last = (r_cnt == 16'(WDATA_LAT - 1));
  assign w_gap_last   = (r_cnt == 16'(READY_GAP - 1));
  assign w_post       = (READY_GAP != 0) ? StGap : StIdle;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic; a simultaneous read and write request is taken as a write
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (mem_size == '0) begin
            w_state_d = w_post;
          end else if (mem_write_req) begin
            w_state_d = StWr;
          end else begin
            w_state_d = StRd;
          end
        end
      end
      StRd:     if (w_beat_last) w_state_d = w_post;
      StWr:     if (w_beat_last) w_state_d = StWdrain;
      StWdrain: if (w_drain_last) w_state_d = w_post;
      StGap:    if (w_gap_last) w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  // Output / datapath decode
  always_comb begin
    w_rd_issue  = (r_state == StRd);
    w_wr_issue  = (r_state == StWr);
    w_beat_addr = r_addr + ADDRW'(r_beat);
    w_ready_d   = (w_state_d == StIdle) && !w_accept;
    w_wreq_d    = (w_state_d == StWr);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_addr  <= '0;
      r_size  <= '0;
      r_be    <= '0;
      r_beat  <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_wreq  <= 1'b0;
    end else begin
      r_ready <= w_ready_d;
      r_wreq  <= w_wreq_d;
      if (w_accept) begin
        r_addr <= mem_local_addr[ADDRW-1:0];
        r_size <= mem_size;
        r_be   <= mem_be;
        r_beat <= '0;
      end else if (w_rd_issue || w_wr_issue) begin
        r_beat <= r_beat + 1'b1;
      end
      if (w_state_d != r_state) begin
        r_cnt <= '0;
      end else if ((r_state == StWdrain) || (r_state == StGap)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Read pipeline: stage 0 is the synchronous RAM read, later stages add latency
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rd_vld <= '0;
      for (int k = 0; k < int'(RDATA_LAT); k++) begin
        r_rd_dat[k] <= '0;
      end
    end else begin
      r_rd_vld[0] <= w_rd_issue;
      if (w_rd_issue) begin
        r_rd_dat[0] <= r_mem[w_beat_addr];
      end
      for (int k = 1; k < int'(RDATA_LAT); k++) begin
        r_rd_vld[k] <= r_rd_vld[k-1];
        r_rd_dat[k] <= r_rd_dat[k-1];
      end
    end
  end

  // Write pipeline: carries each requested beat's address until its data is on mem_wdata
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wp_vld <= '0;
      for (int k = 0; k < int'(WDATA_LAT); k++) begin
        r_wp_addr[k] <= '0;
      end
    end else begin
      r_wp_vld[0]  <= w_wr_issue;
      r_wp_addr[0] <= w_beat_addr;
      for (int k = 1; k < int'(WDATA_LAT); k++) begin
        r_wp_vld[k]  <= r_wp_vld[k-1];
        r_wp_addr[k] <= r_wp_addr[k-1];
      end
    end
  end

  // RAM contents survive reset; a beat pending at reset is dropped
  always_ff @(posedge clk) begin
    if (reset_n && r_wp_vld[WDATA_LAT-1]) begin
      for (int b = 0; b < int'(MEMCONNUMBYTES); b++) begin
        if (r_be[b]) begin
          r_mem[r_wp_addr[WDATA_LAT-1]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  assign mem_ready       = r_ready;
  assign mem_wdata_req   = r_wreq;
  assign mem_rdata       = r_rd_dat[RDATA_LAT-1];
  assign mem_rdata_valid = r_rd_vld[RDATA_LAT-1];

endmodule

// File: tb/tb_ddr_local_responder.sv
// tb_ddr_local_responder: directed self-checking bench for ddr_local_responder.
// Feeds write beats on request, records read beats and compares against a bench-side RAM model.
`timescale 1ns/1ps
module tb_ddr_local_responder;

  localparam int W     = 128;
  localparam int NB    = 16;
  localparam int AW    = 24;
  localparam int BW    = 2;
  localparam int RLAT  = 2;
  localparam int WLAT  = 1;
  localparam int GAP   = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          mem_read_req = 1'b0;
  logic          mem_write_req = 1'b0;
  logic [AW-1:0] mem_local_addr = '0;
  logic [BW-1:0] mem_size = '0;
  logic [NB-1:0] mem_be = '0;
  logic [W-1:0]  mem_wdata = '0;
  logic          burst_begin = 1'b0;
  logic          mem_ready;
  logic          mem_wdata_req;
  logic [W-1:0]  mem_rdata;
  logic          mem_rdata_valid;

  ddr_local_responder #(
    .MEMCONWIDTH   (W),
    .MEMCONNUMBYTES(NB),
    .DDRSIZEWIDTH  (AW),
    .BURSTWIDTH    (BW),
    .ADDRW         (8),
    .RDATA_LAT     (RLAT),
    .WDATA_LAT     (WLAT),
    .READY_GAP     (GAP)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .mem_read_req   (mem_read_req),
    .mem_write_req  (mem_write_req),
    .mem_local_addr (mem_local_addr),
    .mem_size       (mem_size),
    .mem_be         (mem_be),
    .mem_wdata      (mem_wdata),
    .burst_begin    (burst_begin),
    .mem_ready      (mem_ready),
    .mem_wdata_req  (mem_wdata_req),
    .mem_rdata      (mem_rdata),
    .mem_rdata_valid(mem_rdata_valid)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          wreq_cnt = 0;
  logic        pending = 1'b0;
  logic [W-1:0] model [256];
  logic [W-1:0] wq [$];
  logic [W-1:0] rd_data [$];
  int           rd_cyc [$];

  // Monitor/feeder at +1; the main thread acts at +2 to avoid racing it
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (pending) mem_wdata = (wq.size() > 0) ? wq.pop_front() : '0;
    pending = mem_wdata_req;
    if (mem_wdata_req) wreq_cnt++;
    if (mem_rdata_valid) begin
      rd_data.push_back(mem_rdata);
      rd_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic accept(input logic rd, input logic wr, input logic [AW-1:0] a,
                        input logic [BW-1:0] n, input logic [NB-1:0] be, output int t);
    int k = 0;
    while (mem_ready !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    if (mem_ready !== 1'b1) check("ready_timeout", W'(mem_ready), W'(1));
    mem_read_req   = rd;
    mem_write_req  = wr;
    mem_local_addr = a;
    mem_size       = n;
    mem_be         = be;
    t = cyc;
    tick();
    mem_read_req  = 1'b0;
    mem_write_req = 1'b0;
    check("ready_low_after_accept", W'(mem_ready), W'(0));
  endtask

  task automatic expect_ready_at(input string tag, input int t, input int rel);
    int k = 0;
    while (mem_ready !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    check(tag, W'(cyc - t), W'(rel));
  endtask

  task automatic do_write(input logic [AW-1:0] a, input int n, input logic [NB-1:0] be,
                          input logic [W-1:0] d0, input logic [W-1:0] d1,
                          input logic [W-1:0] d2, input logic rd_too);
    int t;
    int w0;
    logic [7:0] idx;
    logic [W-1:0] d [3];
    d = '{d0, d1, d2};
    w0 = wreq_cnt;
    for (int i = 0; i < n; i++) begin
      wq.push_back(d[i]);
      idx = a[7:0] + 8'(i);
      for (int b = 0; b < NB; b++) if (be[b]) model[idx][8*b +: 8] = d[i][8*b +: 8];
    end
    accept(rd_too, 1'b1, a, BW'(n), be, t);
    expect_ready_at("wr_ready_cycle", t, n + WLAT + 1 + GAP);
    check("wr_req_count", W'(wreq_cnt - w0), W'(n));
    check("wr_beats_consumed", W'(wq.size()), W'(0));
    check("wr_no_rdata", W'(rd_data.size()), W'(0));
    rd_data.delete();
    rd_cyc.delete();
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int n);
    int t;
    logic [7:0] idx;
    accept(1'b1, 1'b0, a, BW'(n), '0, t);
    expect_ready_at("rd_ready_cycle", t, n + 1 + GAP);
    check("rd_beat_count", W'(rd_data.size()), W'(n));
    for (int i = 0; i < rd_data.size(); i++) begin
      idx = a[7:0] + 8'(i);
      check("rd_data", rd_data[i], model[idx]);
      check("rd_valid_cycle", W'(rd_cyc[i] - t), W'(1 + RLAT + i));
    end
    rd_data.delete();
    rd_cyc.delete();
  endtask

  initial begin
    int t;
    logic [W-1:0] ones;
    logic [W-1:0] r0, r1;
    ones = '1;

    // Reset state
    repeat (3) tick();
    check("rst_ready", W'(mem_ready), W'(0));
    check("rst_wdata_req", W'(mem_wdata_req), W'(0));
    check("rst_rdata_valid", W'(mem_rdata_valid), W'(0));
    check("rst_rdata", mem_rdata, '0);
    reset_n = 1'b1;
    tick();
    check("ready_after_reset", W'(mem_ready), W'(1));

    // 1) Basic write then read-back
    do_write(24'h000010, 2, '1, 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF,
             128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF, '0, 1'b0);
    do_read(24'h000010, 2);

    // 2) Byte-enable merge over all-ones
    do_write(24'h000020, 1, '1, ones, '0, '0, 1'b0);
    do_write(24'h000020, 1, 16'h00FF, 128'h11223344_55667788_99AABBCC_DDEEFF00, '0, '0, 1'b0);
    do_read(24'h000020, 1);
    check("be_merge_model", model[8'h20], 128'hFFFFFFFF_FFFFFFFF_99AABBCC_DDEEFF00);

    // 3) Address wrap, upper address bits ignored
    do_write(24'h1230FF, 2, '1, 128'hC0DE_0000_0000_0000_0000_0000_0000_00FF,
             128'hC0DE_0000_0000_0000_0000_0000_0000_0100, '0, 1'b0);
    do_read(24'h0000FF, 1);
    do_read(24'h000000, 1);
    do_read(24'hAB00FF, 2);

    // 4) Read+write together is a write; zero-size read has no beats
    do_write(24'h000050, 1, '1, 128'h5050_5050, '0, '0, 1'b1);
    do_read(24'h000050, 1);
    do_read(24'h000050, 0);

    // 5) Reset during a write burst after beat 0
    do_write(24'h000040, 2, '1, 128'h4000, 128'h4001, '0, 1'b0);
    wq.push_back(128'hBEEF_0000);
    wq.push_back(128'hBEEF_0001);
    accept(1'b0, 1'b1, 24'h000040, 2'd2, '1, t);
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    check("midrst_ready", W'(mem_ready), W'(0));
    check("midrst_wdata_req", W'(mem_wdata_req), W'(0));
    check("midrst_rdata_valid", W'(mem_rdata_valid), W'(0));
    check("midrst_rdata", mem_rdata, '0);
    reset_n = 1'b1;
    tick();
    check("midrst_ready_release", W'(mem_ready), W'(1));
    check("midrst_no_rdata", W'(rd_data.size()), W'(0));
    check("midrst_wq_drained", W'(wq.size()), W'(0));
    model[8'h40] = 128'hBEEF_0000;
    do_read(24'h000040, 2);

    // 6) Read/read/write rounds with random stalls
    for (int i = 0; i < 8; i++) begin
      r0 = {$urandom, $urandom, $urandom, $urandom};
      r1 = {$urandom, $urandom, $urandom, $urandom};
      do_write(24'h80 + 24'(2 * i), 2, '1, r0, r1, '0, 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 4)) tick();
      do_read(24'h80 + 24'($urandom_range(0, 12)), int'($urandom_range(1, 3)));
      repeat ($urandom_range(0, 4)) tick();
      do_read(24'h80 + 24'($urandom_range(0, 12)), int'($urandom_range(1, 3)));
      repeat ($urandom_range(0, 4)) tick();
      do_write(24'h80 + 24'($urandom_range(0, 12)), int'($urandom_range(1, 3)),
               NB'($urandom_range(0, 65535)),
               {$urandom, $urandom, $urandom, $urandom},
               {$urandom, $urandom, $urandom, $urandom},
               {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    end
    do_read(24'h000080, 3);
    do_read(24'h000083, 3);
    do_read(24'h000086, 3);
    do_read(24'h000089, 3);
    do_read(24'h00008C, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
